mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/data memory between three requesters: the program loader
//  (fm write port), the memory stage (LDD/STD/PUSH/POP) and the fetch stage of the pipelined
//  processor. It also sequences boot: it holds the core in reset until loading is done.
//  It sits between the memory and the pipeline; the pipeline sees per-port stalls and read-valids.
// PARAMETERS
//  ADDR_W      20  memory word-address width
//  DATA_W      16  memory word width (instruction width)
//  STARVE_MAX  4   consecutive fetch denials by the data port before fetch is forced a grant
//  RST_HOLD    2   cycles the core reset stays high after ld_done
// PORTS
//  clk        in   1       clock; everything is sampled on the rising edge
//  reset      in   1       synchronous, active-high reset
//  ld_en      in   1       loader write request (write only)
//  ld_addr    in   ADDR_W  loader address
//  ld_data    in   DATA_W  loader write data
//  ld_done    in   1       one-cycle pulse: program load complete
//  d_req      in   1       memory-stage request
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  memory-stage address
//  d_wdata    in   DATA_W  memory-stage write data
//  d_stall    out  1       memory-stage request not granted this cycle
//  d_rvalid   out  1       d_rdata is valid (read response)
//  d_rdata    out  DATA_W  memory-stage read data
//  f_req      in   1       fetch read request
//  f_addr     in   ADDR_W  fetch address (PC)
//  f_stall    out  1       fetch request not granted this cycle
//  f_rvalid   out  1       f_rdata is valid
//  f_rdata    out  DATA_W  fetched instruction
//  cpu_rst    out  1       reset to the pipeline core
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data; synchronous, valid 1 cycle after mem_en with !mem_we
// BEHAVIOUR
//  Reset values: state=BOOT, cpu_rst=1, all stalls/rvalids=0, mem_en=mem_we=0, mem_addr/wdata=0,
//   rdata outputs=0, starvation counter=0, read-owner tag=NONE. Reset mid-read drops the response.
//  FSM: BOOT -(ld_done)-> HOLD -(RST_HOLD cycles elapsed)-> RUN. RUN is terminal until reset.
//   BOOT: only the loader is served. d_req and f_req are stalled; cpu_rst=1.
//   HOLD: counts RST_HOLD cycles with cpu_rst=1; the loader is still served.
//   RUN: cpu_rst=0. Full arbitration applies.
//  Arbitration (combinational each cycle; the memory bus is registered, see latency):
//   priority ld_en > starved fetch > d_req > f_req; exactly one grant per cycle.
//   "Starved fetch": starve_cnt==STARVE_MAX and f_req=1.
//   Loser request sees stall=1 in the same cycle; the requester holds its request stable until stall=0.
//   ld_en in RUN is a debug write: it stalls both pipeline ports.
//  Starvation counter: increments when f_req=1 and fetch is denied by d_req; clears on a fetch grant
//   or when f_req=0; saturates at STARVE_MAX.
//  Latency: the granted request drives mem_* registered, 1 cycle after the grant.
//   Read data returns on mem_rdata one cycle after that.
//   rvalid pulses 2 cycles after the grant, on the port named by a 2-stage owner tag pipeline.
//   rdata is registered from mem_rdata and holds its last value when rvalid=0.
//  Writes (ld or d with d_we=1) never produce an rvalid. The loader write uses ld_addr/ld_data.
//  Back-to-back: a new grant is allowed every cycle. Responses return in grant order; no extra
//   bubbles are inserted.
//  ld_done during HOLD or RUN is ignored. ld_done together with ld_en in BOOT: the write is
//   performed and the state moves to HOLD.
//  Address and data pass through at full width; no wrap or truncation.
// TESTING
//  1 Boot: reset; 3 loader writes at 0x20..0x22 (0xC95F, 0x647F, 0x1F3D); ld_done.
//    -> mem_we pulses with those address/data pairs; cpu_rst falls exactly RST_HOLD+1 cycles after ld_done.
//  2 Fetch in RUN: f_req at 0x20 -> f_stall=0, f_rvalid=1 two cycles later with f_rdata=0xC95F.
//  3 Conflict: d_req read 0x02 and f_req together -> d granted, f_stall=1 for that cycle;
//    d_rvalid arrives two cycles later with the memory contents; the fetch is served the next cycle.
//  4 Starvation: d_req held high for 10 cycles with f_req=1
//    -> fetch is granted on cycle 5 (STARVE_MAX=4 denials), d_stall=1 in that cycle.
//  5 Debug write in RUN: ld_en with d_req and f_req -> both stall, mem_we=1 with ld_addr;
//    no rvalid is generated.
//  6 Reset mid-read: assert reset the cycle after a d read grant
//    -> d_rvalid stays 0; state=BOOT; cpu_rst=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the program loader, the memory stage and fetch,
// and holds the pipeline core in reset until the program image is loaded.
module mem_port_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int RST_HOLD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_stall,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              cpu_rst,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {BOOT, HOLD, RUN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_F} owner_t;

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int HC_W = $clog2(RST_HOLD + 1);
  localparam logic [SC_W-1:0] STARVE_FULL = SC_W'(STARVE_MAX);
  localparam logic [HC_W-1:0] HOLD_LAST   = HC_W'(RST_HOLD - 1);

  state_t            state, state_nxt;
  logic [HC_W-1:0]   hold_cnt, hold_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  owner_t            tag0, tag1, bus_owner;
  logic              ld_gnt, d_gnt, f_gnt, starved;
  logic              bus_en, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] d_rdata_q, f_rdata_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      BOOT: if (ld_done) begin
        state_nxt = HOLD;
        hold_nxt  = '0;
      end
      HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
            else hold_nxt = hold_cnt + 1'b1;
      RUN:  ;
      default: state_nxt = BOOT;
    endcase
  end

  // Loader always wins; pipeline ports compete only once the core is running.
  always_comb begin
    ld_gnt  = 1'b0;
    d_gnt   = 1'b0;
    f_gnt   = 1'b0;
    starved = f_req && (starve_cnt == STARVE_FULL);
    if (ld_en)               ld_gnt = 1'b1;
    else if (state == RUN) begin
      if (starved)           f_gnt  = 1'b1;
      else if (d_req)        d_gnt  = 1'b1;
      else if (f_req)        f_gnt  = 1'b1;
    end
  end

  // Only denials caused by the data port count toward starvation.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!f_req || f_gnt)                      starve_nxt = '0;
    else if (d_gnt && starve_cnt != STARVE_FULL) starve_nxt = starve_cnt + 1'b1;
  end

  always_comb begin
    bus_en    = ld_gnt | d_gnt | f_gnt;
    bus_we    = 1'b0;
    bus_addr  = mem_addr;
    bus_wdata = mem_wdata;
    bus_owner = OWN_NONE;
    if (ld_gnt) begin
      bus_we    = 1'b1;
      bus_addr  = ld_addr;
      bus_wdata = ld_data;
    end else if (d_gnt) begin
      bus_we    = d_we;
      bus_addr  = d_addr;
      bus_wdata = d_wdata;
      bus_owner = d_we ? OWN_NONE : OWN_D;
    end else if (f_gnt) begin
      bus_addr  = f_addr;
      bus_owner = OWN_F;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      hold_cnt   <= '0;
      starve_cnt <= '0;
      tag0       <= OWN_NONE;
      tag1       <= OWN_NONE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      d_rdata_q  <= '0;
      f_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      starve_cnt <= starve_nxt;
      tag0       <= bus_owner;
      tag1       <= tag0;
      mem_en     <= bus_en;
      mem_we     <= bus_we;
      mem_addr   <= bus_addr;
      mem_wdata  <= bus_wdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
      if (f_rvalid) f_rdata_q <= mem_rdata;
    end
  end

  // Read data is presented in the response cycle and held afterwards.
  assign d_rvalid = (tag1 == OWN_D);
  assign f_rvalid = (tag1 == OWN_F);
  assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
  assign f_rdata  = f_rvalid ? mem_rdata : f_rdata_q;
  assign d_stall  = d_req & ~d_gnt;
  assign f_stall  = f_req & ~f_gnt;
  assign cpu_rst  = (state != RUN);

endmodule
